// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-borrow subtractor.
//   {bor_out, diff} = a - b - bor_in, one-cycle latency, out_valid tracks in_valid.
//   Optional build macro FULL_ADDER_ZERO_FLAG_EN adds a registered 'zero' output
//   that is high when the loaded difference is all zeros.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bor_in,
  output logic [WIDTH-1:0] diff,
  output logic             bor_out,
  output logic             out_valid
`ifdef FULL_ADDER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned BW = WIDTH + 1;

  logic [BW-1:0]    br_c;
  logic [WIDTH-1:0] diff_d;
  logic             bor_d;
  logic [WIDTH-1:0] diff_q;
  logic             bor_q;
  logic             valid_q;

  // Ripple-borrow chain: one subtractor cell per bit, borrow enters at the LSB.
  always_comb begin
    br_c    = '0;
    diff_d  = '0;
    br_c[0] = bor_in;
    for (int i = 0; i < int'(WIDTH); i++) begin
      diff_d[i]  = a[i] ^ b[i] ^ br_c[i];
      br_c[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br_c[i]);
    end
    bor_d = br_c[WIDTH];
  end

  // Result registers load only on a valid beat so an idle bus never disturbs them.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q  <= '0;
      bor_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q <= diff_d;
        bor_q  <= bor_d;
      end
    end
  end

  assign diff      = diff_q;
  assign bor_out   = bor_q;
  assign out_valid = valid_q;

`ifdef FULL_ADDER_ZERO_FLAG_EN
  logic zero_d;
  logic zero_q;

  assign zero_d = (diff_d == WIDTH'(0));

  // Zero flag is captured together with the difference it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (in_valid) begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder (WIDTH=1 and WIDTH=8 instances).
module tb_full_adder;

  logic       clk;
  logic       rst;
  logic       v1, v8;
  logic [0:0] a1, b1;
  logic       bi1, bi8;
  logic [7:0] a8, b8;
  logic [0:0] d1;
  logic       bo1, ov1;
  logic [7:0] d8;
  logic       bo8, ov8;
`ifdef FULL_ADDER_ZERO_FLAG_EN
  logic       z1, z8;
`endif

  int checks   = 0;
  int failures = 0;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .bor_in(bi1),
    .diff(d1), .bor_out(bo1), .out_valid(ov1)
`ifdef FULL_ADDER_ZERO_FLAG_EN
    , .zero(z1)
`endif
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .bor_in(bi8),
    .diff(d8), .bor_out(bo8), .out_valid(ov8)
`ifdef FULL_ADDER_ZERO_FLAG_EN
    , .zero(z8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_d1;
  logic [7:0] exp_b1;
  logic [2:0] combo;

  initial begin
    exp_d1 = 8'b1001_0110;  // diff for combos 7..0
    exp_b1 = 8'b1000_1110;  // borrow for combos 7..0
    rst = 1'b1; v1 = 1'b0; v8 = 1'b0;
    a1 = '0; b1 = '0; bi1 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    tick();
    tick();
    check("rst_diff1", 32'(d1), 32'h0);
    check("rst_bor1", 32'(bo1), 32'h0);
    check("rst_valid1", 32'(ov1), 32'h0);
    check("rst_diff8", 32'(d8), 32'h0);
    rst = 1'b0;

    // All eight 1-bit combinations back to back.
    for (int k = 0; k < 8; k++) begin
      combo = 3'(k);
      a1 = combo[2]; b1 = combo[1]; bi1 = combo[0]; v1 = 1'b1;
      if (k > 0) begin
        #1;
        check($sformatf("latency_hold%0d", k), 32'(d1), 32'(exp_d1[k-1]));
      end
      tick();
      check($sformatf("w1_diff%0d", k), 32'(d1), 32'(exp_d1[k]));
      check($sformatf("w1_bor%0d", k), 32'(bo1), 32'(exp_b1[k]));
      check($sformatf("w1_valid%0d", k), 32'(ov1), 32'h1);
    end

    // Reset discards a loaded result; rst wins over in_valid.
    a1 = 1'b0; b1 = 1'b1; bi1 = 1'b0; v1 = 1'b1;
    tick();
    check("pre_rst_diff", 32'(d1), 32'h1);
    check("pre_rst_bor", 32'(bo1), 32'h1);
    rst = 1'b1;
    tick();
    check("rst_mid_diff", 32'(d1), 32'h0);
    check("rst_mid_bor", 32'(bo1), 32'h0);
    check("rst_mid_valid", 32'(ov1), 32'h0);
    rst = 1'b0; v1 = 1'b0;

    // 8-bit wrap-around and a normal subtraction.
    a8 = 8'h00; b8 = 8'h00; bi8 = 1'b1; v8 = 1'b1;
    tick();
    check("w8_wrap_diff", 32'(d8), 32'hFF);
    check("w8_wrap_bor", 32'(bo8), 32'h1);
    a8 = 8'h5A; b8 = 8'h3C; bi8 = 1'b0;
    tick();
    check("w8_5a3c_diff", 32'(d8), 32'h1E);
    check("w8_5a3c_bor", 32'(bo8), 32'h0);
    check("w8_5a3c_valid", 32'(ov8), 32'h1);
`ifdef FULL_ADDER_ZERO_FLAG_EN
    check("w8_5a3c_zero", 32'(z8), 32'h0);
`endif

    // Idle bus: result holds, valid drops.
    v8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      tick();
      check($sformatf("hold_diff%0d", k), 32'(d8), 32'h1E);
      check($sformatf("hold_bor%0d", k), 32'(bo8), 32'h0);
      check($sformatf("hold_valid%0d", k), 32'(ov8), 32'h0);
    end

    // Three back-to-back operands.
    v8 = 1'b1;
    a8 = 8'h80; b8 = 8'h01; bi8 = 1'b0;
    tick();
    check("b2b0_diff", 32'(d8), 32'h7F);
    check("b2b0_bor", 32'(bo8), 32'h0);
    check("b2b0_valid", 32'(ov8), 32'h1);
    a8 = 8'h03; b8 = 8'h05; bi8 = 1'b1;
    tick();
    check("b2b1_diff", 32'(d8), 32'hFD);
    check("b2b1_bor", 32'(bo8), 32'h1);
    check("b2b1_valid", 32'(ov8), 32'h1);
    a8 = 8'hFF; b8 = 8'hFE; bi8 = 1'b1;
    tick();
    check("b2b2_diff", 32'(d8), 32'h00);
    check("b2b2_bor", 32'(bo8), 32'h0);
    check("b2b2_valid", 32'(ov8), 32'h1);

    // All-ones minus zero: no borrow.
    a8 = 8'hFF; b8 = 8'h00; bi8 = 1'b0;
    tick();
    check("ones_diff", 32'(d8), 32'hFF);
    check("ones_bor", 32'(bo8), 32'h0);

    // Exact-zero result.
    a8 = 8'h10; b8 = 8'h0F; bi8 = 1'b1;
    tick();
    check("zres_diff", 32'(d8), 32'h00);
    check("zres_bor", 32'(bo8), 32'h0);
`ifdef FULL_ADDER_ZERO_FLAG_EN
    check("zres_zero", 32'(z8), 32'h1);
`endif
    v8 = 1'b0;
    tick();
    check("end_valid", 32'(ov8), 32'h0);
    check("end_hold", 32'(d8), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
